// File: rtl/onehot_pulse_decoder.sv
// Decodes an encoded index (plus NONE flag) back to a one-hot line held for HOLD cycles,
// followed by a GAP-cycle idle gap. Optional malformed-input checking via DEC_ERR_CHECK_EN.
module onehot_pulse_decoder #(
    parameter int W    = 3,
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_idx,
    input  logic                in_none,
    output logic [(1<<W)-1:0]   out_onehot,
    output logic                out_active,
    output logic                done
`ifdef DEC_ERR_CHECK_EN
   ,output logic                err,
    output logic [7:0]          err_cnt
`endif
);

    localparam int N         = 1 << W;
    localparam int MAXC      = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW        = $clog2(MAXC + 1);
    localparam int HOLD_LOAD = HOLD - 1;
    localparam int GAP_LOAD  = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    idx_q, idx_d;
    logic [N-1:0]    onehot_d;
    logic            active_d;
    logic            done_d;
    logic            accept;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            out_onehot <= '0;
            out_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            out_onehot <= onehot_d;
            out_active <= active_d;
            done       <= done_d;
        end
    end

    // Counter reaching zero marks the last cycle of the current HOLD or GAP phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !in_none) begin
                    state_d = ST_HOLD;
                    cnt_d   = CW'(HOLD_LOAD);
                    idx_d   = in_idx;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = CW'(GAP_LOAD);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs; the pulse drops on the same edge done rises.
    always_comb begin
        onehot_d = '0;
        active_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && !in_none) begin
                    onehot_d = N'(1) << in_idx;
                    active_d = 1'b1;
                end else if (accept && in_none) begin
                    done_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                end else begin
                    onehot_d = N'(1) << idx_q;
                    active_d = 1'b1;
                end
            end
            default: begin
                onehot_d = '0;
            end
        endcase
    end

`ifdef DEC_ERR_CHECK_EN
    logic malformed;

    // The encoder always drives a zero index alongside NONE, so anything else is flagged.
    assign malformed = accept && in_none && (in_idx != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else if (malformed) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Self-checking bench for onehot_pulse_decoder: directed steps then random traffic, compared
// against a timestamp-based reference model. Define DEC_ERR_CHECK_EN to cover the error outputs.
module tb_onehot_pulse_decoder;

    localparam int W    = 3;
    localparam int HOLD = 4;
    localparam int GAP  = 1;
    localparam int N    = 1 << W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_idx = '0;
    logic           in_none = 1'b0;
    logic [N-1:0]   out_onehot;
    logic           out_active;
    logic           done;
`ifdef DEC_ERR_CHECK_EN
    logic           err;
    logic [7:0]     err_cnt;
`endif

    onehot_pulse_decoder #(.W(W), .HOLD(HOLD), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_none    (in_none),
        .out_onehot (out_onehot),
        .out_active (out_active),
        .done       (done)
`ifdef DEC_ERR_CHECK_EN
       ,.err        (err),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: remembers the edge at which the last pulse and last NONE were accepted.
    int             now = 0;
    bit             pulse_valid = 0;
    int             pulse_edge = -1000;
    int             pulse_idx = 0;
    int             none_edge = -1000;
    bit             last_acc = 0;
    bit             err_exp = 0;
    int             errcnt_exp = 0;

    function automatic bit modelReady();
        return !pulse_valid || ((now - pulse_edge) >= HOLD + GAP);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, now);
        end
    endtask

    task automatic checkOutput();
        int          rel;
        logic [31:0] exp_onehot;
        logic        exp_done;
        rel        = now - pulse_edge;
        exp_onehot = (pulse_valid && rel >= 0 && rel < HOLD) ? (32'd1 << pulse_idx) : 32'd0;
        exp_done   = (now == none_edge) || (pulse_valid && rel == HOLD);
        checkVal("out_onehot", 32'(out_onehot), exp_onehot);
        checkVal("out_active", 32'(out_active), 32'(exp_onehot != 0));
        checkVal("done", 32'(done), 32'(exp_done));
        checkVal("in_ready", 32'(in_ready), 32'(modelReady()));
`ifdef DEC_ERR_CHECK_EN
        checkVal("err", 32'(err), 32'(err_exp));
        checkVal("err_cnt", 32'(err_cnt), 32'(errcnt_exp));
`endif
    endtask

    // Drives one cycle of input at the falling edge, advances the model across the rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] i, input logic n);
        bit acc;
        in_valid = v;
        in_idx   = i;
        in_none  = n;
        acc      = v && modelReady();
        @(posedge clk);
        now++;
        if (acc && !n) begin
            pulse_valid = 1;
            pulse_edge  = now;
            pulse_idx   = int'(i);
        end else if (acc && n) begin
            none_edge = now;
            if (i != '0) begin
                err_exp = 1;
                if (errcnt_exp < 255) errcnt_exp++;
            end
        end
        last_acc = acc;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyReset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_none  = 1'b0;
        in_idx   = '0;
        @(posedge clk);
        now++;
        pulse_valid = 0;
        none_edge   = -1000;
        err_exp     = 0;
        errcnt_exp  = 0;
        @(negedge clk);
        checkOutput();
        rst_n = 1'b1;
    endtask

    task automatic sendHeld(input logic [W-1:0] i, input logic n);
        last_acc = 0;
        for (int k = 0; k < 20 && !last_acc; k++) begin
            applyStimulus(1'b1, i, n);
        end
        checkVal("held_accept", 32'(last_acc), 32'd1);
    endtask

    initial begin
        @(negedge clk);
        $display("[TB] reset");
        applyReset();
        applyReset();

        $display("[TB] single pulse idx 5");
        applyStimulus(1'b1, 3'd5, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 3'd0, 1'b0);

        $display("[TB] all indices back-to-back");
        for (int i = 0; i < N; i++) sendHeld(W'(i), 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 3'd0, 1'b0);

        $display("[TB] NONE transfers");
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 3'd0, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0);

        $display("[TB] valid during busy");
        applyStimulus(1'b1, 3'd7, 1'b0);
        sendHeld(3'd2, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 3'd0, 1'b0);

        $display("[TB] reset mid-pulse");
        applyStimulus(1'b1, 3'd3, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0);
        applyReset();
        applyStimulus(1'b0, 3'd0, 1'b0);

`ifdef DEC_ERR_CHECK_EN
        $display("[TB] malformed inputs");
        applyStimulus(1'b1, 3'd3, 1'b1);
        applyStimulus(1'b1, 3'd3, 1'b1);
        checkVal("err_cnt_two", 32'(err_cnt), 32'd2);
        for (int k = 0; k < 300; k++) applyStimulus(1'b1, W'($urandom_range(1, N - 1)), 1'b1);
        checkVal("err_cnt_sat", 32'(err_cnt), 32'd255);
        applyReset();
`endif

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, N - 1)),
                          1'($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
